// File: rtl/smem_output_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : smem_output_scheduler
// Description : Shares one DATA_W-bit host write channel between NUM_PE
//               result buffers. The buffers are served one at a time in
//               round-robin order. Each granted buffer streams beats into an
//               output FIFO until it reports finish. When every buffer has
//               been served and the FIFO has drained, batch_done pulses.
//
// Ports
//   clk          in   single clock, all logic on posedge
//   reset        in   synchronous, active-high
//   batch_start  in   pulse in DONE: clears served mask, counters, rr pointer
//   pe_request   in   per-buffer output_request
//   pe_permit    out  per-buffer output_permit (registered, one-hot or zero)
//   pe_stall     out  per-buffer stall (non-granted buffers held stalled)
//   pe_data      in   beats, buffer i at [i*DATA_W +: DATA_W]
//   pe_valid     in   per-buffer output_valid
//   pe_finish    in   per-buffer output_finish (sticky)
//   out_data     out  FIFO head
//   out_valid    out  FIFO non-empty
//   out_ready    in   host accepts a beat when out_valid & out_ready
//   batch_done   out  one-cycle pulse at end of batch
//   beat_count   out  beats accepted this batch (wraps)
//   protocol_err out  sticky: stray valid or push into a full FIFO
//
// Revision    : 1.0 - initial release
// ============================================================================
module smem_output_scheduler #(
    parameter int NUM_PE     = 4,
    parameter int DATA_W     = 512,
    parameter int FIFO_DEPTH = 16,
    parameter int SLACK      = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       batch_start,
    input  logic [NUM_PE-1:0]          pe_request,
    output logic [NUM_PE-1:0]          pe_permit,
    output logic [NUM_PE-1:0]          pe_stall,
    input  logic [NUM_PE*DATA_W-1:0]   pe_data,
    input  logic [NUM_PE-1:0]          pe_valid,
    input  logic [NUM_PE-1:0]          pe_finish,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       batch_done,
    output logic [31:0]                beat_count,
    output logic                       protocol_err
);

    localparam int PW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_GRANT = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // Number of DRAIN cycles minus one: covers the buffer's output pipe tail.
    localparam logic [1:0] DRAIN_LAST = 2'd2;

    // (base + ofs) mod NUM_PE, for ofs < NUM_PE
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int ofs);
        int s;
        s = int'(base) + ofs;
        if (s >= NUM_PE) begin
            s = s - NUM_PE;
        end
        return s[PW-1:0];
    endfunction

    // ---------------- FSM / arbitration state ----------------
    logic [2:0]        state_q,  state_d;
    logic [PW-1:0]     gnt_q,    gnt_d;
    logic [PW-1:0]     rr_q,     rr_d;
    logic [NUM_PE-1:0] served_q, served_d;
    logic [1:0]        drain_q,  drain_d;
    logic [NUM_PE-1:0] permit_q, permit_d;
    logic              done_q,   done_d;

    // ---------------- FIFO / datapath state ----------------
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_q;
    logic [AW-1:0]     rd_q;
    logic [CW-1:0]     cnt_q;
    logic [31:0]       beat_q;
    logic              err_q;

    logic              w_found;
    logic [PW-1:0]     w_pick;
    logic              w_active;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic              w_err_evt;
    logic              w_low_room;
    logic [CW-1:0]     w_free;
    logic [NUM_PE-1:0] w_gnt_oh;
    logic [DATA_W-1:0] w_slice;

    // Round-robin scan: descending loop so the smallest offset from rr_q wins.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = NUM_PE - 1; k >= 0; k--) begin
            if (pe_request[wrap_add(rr_q, k)] && !served_q[wrap_add(rr_q, k)]) begin
                w_found = 1'b1;
                w_pick  = wrap_add(rr_q, k);
            end
        end
    end

    // ---------------- FSM process 1: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            gnt_q    <= '0;
            rr_q     <= '0;
            served_q <= '0;
            drain_q  <= '0;
            permit_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_q     <= rr_d;
            served_q <= served_d;
            drain_q  <= drain_d;
            permit_q <= permit_d;
            done_q   <= done_d;
        end
    end

    // ---------------- FSM process 2: next state ----------------
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_d     = rr_q;
        served_d = served_q;
        drain_d  = drain_q;
        case (state_q)
            S_IDLE: begin
                if (w_found) begin
                    gnt_d   = w_pick;
                    state_d = S_GRANT;
                end else if (&served_q) begin
                    state_d = S_FLUSH;
                end
            end
            S_GRANT: begin
                if (pe_finish[gnt_q]) begin
                    served_d[gnt_q] = 1'b1;
                    rr_d            = wrap_add(gnt_q, 1);
                    drain_d         = '0;
                    state_d         = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            S_FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (batch_start) begin
                    served_d = '0;
                    rr_d     = '0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM process 3: outputs ----------------
    always_comb begin
        w_gnt_oh        = '0;
        w_gnt_oh[gnt_q] = 1'b1;
        w_active  = (state_q == S_GRANT) || (state_q == S_DRAIN);
        w_full    = (cnt_q == CW'(FIFO_DEPTH));
        w_push    = w_active && pe_valid[gnt_q] && !w_full;
        w_pop     = (cnt_q != '0) && out_ready;
        // Any valid outside the currently granted buffer is a stray beat.
        w_err_evt = (|(pe_valid & ~(w_active ? w_gnt_oh : '0)))
                  || (w_active && pe_valid[gnt_q] && w_full);
        // Permit is driven one cycle after the grant is latched and drops the
        // cycle after finish is seen.
        permit_d  = (state_q == S_GRANT && !pe_finish[gnt_q]) ? w_gnt_oh : '0;
        done_d    = (state_q == S_FLUSH) && (cnt_q == '0);
    end

    // Stall is a function of the registered occupancy only, giving the
    // buffer's output pipe SLACK entries of headroom.
    assign w_free     = CW'(FIFO_DEPTH) - cnt_q;
    assign w_low_room = (w_free <= CW'(SLACK));

    generate
        for (genvar i = 0; i < NUM_PE; i++) begin : g_stall
            assign pe_stall[i] = (gnt_q == PW'(i)) ? w_low_room : 1'b1;
        end
    endgenerate

    assign w_slice = pe_data[int'(gnt_q)*DATA_W +: DATA_W];

    // ---------------- FIFO storage (no reset: contents discarded by pointers) ----------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_q] <= w_slice;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            beat_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (w_push) begin
                wr_q <= wr_q + AW'(1);
            end
            if (w_pop) begin
                rd_q <= rd_q + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (state_q == S_DONE && batch_start) begin
                beat_q <= '0;
            end else if (w_push) begin
                beat_q <= beat_q + 32'd1;
            end
            if (w_err_evt) begin
                err_q <= 1'b1;
            end
        end
    end

    assign pe_permit    = permit_q;
    assign out_data     = mem_q[rd_q];
    assign out_valid    = (cnt_q != '0);
    assign batch_done   = done_q;
    assign beat_count   = beat_q;
    assign protocol_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_smem_output_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_smem_output_scheduler
// Description : Randomised bench for smem_output_scheduler. A cycle driver
//               plays the role of the result buffers and the host; expected
//               beats and grant order go into queues; an independent monitor
//               tracks FIFO occupancy and compares outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_smem_output_scheduler;

    localparam int NP    = 4;
    localparam int W     = 512;
    localparam int DEPTH = 16;
    localparam int SLACK = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              batch_start;
    logic [NP-1:0]     pe_request;
    logic [NP-1:0]     pe_permit;
    logic [NP-1:0]     pe_stall;
    logic [NP*W-1:0]   pe_data;
    logic [NP-1:0]     pe_valid;
    logic [NP-1:0]     pe_finish;
    logic [W-1:0]      out_data;
    logic              out_valid;
    logic              out_ready;
    logic              batch_done;
    logic [31:0]       beat_count;
    logic              protocol_err;

    smem_output_scheduler #(
        .NUM_PE(NP), .DATA_W(W), .FIFO_DEPTH(DEPTH), .SLACK(SLACK)
    ) dut (
        .clk(clk), .reset(reset), .batch_start(batch_start),
        .pe_request(pe_request), .pe_permit(pe_permit), .pe_stall(pe_stall),
        .pe_data(pe_data), .pe_valid(pe_valid), .pe_finish(pe_finish),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .batch_done(batch_done), .beat_count(beat_count), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_beat();
        logic [W-1:0] b;
        for (int k = 0; k < W/32; k++) b[k*32 +: 32] = $urandom;
        return b;
    endfunction

    function automatic int idx_of(input logic [NP-1:0] v);
        for (int i = 0; i < NP; i++) if (v[i]) return i;
        return -1;
    endfunction

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           exp_gnt[$];
    int           occ      = 0;
    int           done_cnt = 0;
    logic [NP-1:0] prev_permit = '0;

    always @(negedge clk) begin
        if (!reset) begin
            check("out_valid_vs_occupancy", out_valid, occ != 0);
            if (pe_permit != '0) begin
                for (int i = 0; i < NP; i++)
                    check($sformatf("stall_pe%0d", i), pe_stall[i],
                          pe_permit[i] ? ((DEPTH - occ) <= SLACK) : 1'b1);
            end
            if (pe_permit != prev_permit && pe_permit != '0) begin
                check("permit_onehot", $onehot(pe_permit), 1);
                if (exp_gnt.size() == 0) begin
                    check("unexpected_grant", idx_of(pe_permit), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    check("grant_order", idx_of(pe_permit), exp_gnt.pop_front());
                end
            end
            if (out_valid && out_ready) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL out_data: got beat %0h expected none", out_data[63:0]);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        n_fail++;
                        $display("FAIL out_data: got %0h expected %0h", out_data[127:0], e[127:0]);
                    end
                end
            end
            if (batch_done) begin
                done_cnt++;
                check("done_with_fifo_empty", out_valid, 0);
            end
            occ = occ + ((|(pe_valid & pe_permit)) ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
        end else begin
            occ = 0;
        end
        prev_permit = pe_permit;
    end

    // ---------------- buffer / host agent ----------------
    int nbeats[NP];
    int grp[NP];
    int dly[NP];
    int sent[NP];
    bit fin[NP];
    int cyc, gap_pct, ready_pct, ready_hold, ign_start_cyc, stall_chk_cyc, m_rr;
    bit inj_en, inj_done;

    // Round-robin order from the rule: requests arrive in groups; each group
    // is served fully, scanning upward from the pointer left by the last grant.
    task automatic model_grants();
        bit pend[NP];
        int maxg = -1;
        for (int i = 0; i < NP; i++) if (grp[i] > maxg) maxg = grp[i];
        for (int g = 0; g <= maxg; g++) begin
            for (int i = 0; i < NP; i++) pend[i] = (grp[i] == g);
            for (int n = 0; n < NP; n++) begin
                for (int k = 0; k < NP; k++) begin
                    int p;
                    p = (m_rr + k) % NP;
                    if (pend[p]) begin
                        exp_gnt.push_back(p);
                        pend[p] = 0;
                        m_rr = (p + 1) % NP;
                        break;
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
        cyc++;
        batch_start = 1'b0;
        pe_valid    = '0;
        for (int i = 0; i < NP; i++) begin
            if (!fin[i] && dly[i] >= 0 && cyc >= dly[i]) pe_request[i] = 1'b1;
            if (pe_permit[i] && !fin[i]) begin
                if (sent[i] < nbeats[i]) begin
                    if (!pe_stall[i] && $urandom_range(0, 99) >= gap_pct) begin
                        logic [W-1:0] d;
                        d = rnd_beat();
                        pe_data[i*W +: W] = d;
                        pe_valid[i] = 1'b1;
                        exp_q.push_back(d);
                        sent[i]++;
                    end
                end else begin
                    pe_finish[i]  = 1'b1;
                    pe_request[i] = 1'b0;
                    fin[i]        = 1'b1;
                end
            end
        end
        if (inj_en && !inj_done && pe_permit[0]) begin
            pe_data[W +: W] = rnd_beat();
            pe_valid[1] = 1'b1;
            inj_done    = 1'b1;
        end
        if (cyc == ign_start_cyc) batch_start = 1'b1;
        out_ready = (cyc <= ready_hold) ? 1'b0 : ($urandom_range(0, 99) < ready_pct);
        if (cyc == stall_chk_cyc) begin
            check("pe0_beats_before_stall", sent[0], 12);
            check("pe0_stall_at_12", pe_stall[0], 1);
        end
    endtask

    task automatic begin_batch(input bit use_start);
        if (use_start) begin
            batch_start = 1'b1;
            m_rr = 0;
        end
        cyc = 0; inj_done = 0;
        pe_finish  = '0;
        pe_request = '0;
        for (int i = 0; i < NP; i++) begin
            sent[i] = 0;
            fin[i]  = (grp[i] < 0);
            dly[i]  = (grp[i] < 0) ? -1 : grp[i] * 100;
        end
        model_grants();
    endtask

    task automatic run_batch(input string tag, input bit use_start, input int exp_done, input bit exp_err);
        int start_done, total;
        bit seen;
        begin_batch(use_start);
        start_done = done_cnt;
        seen  = 0;
        total = 0;
        for (int i = 0; i < NP; i++) total += nbeats[i];
        for (int t = 0; t < 3000; t++) begin
            step();
            if (done_cnt != start_done) begin
                seen = 1;
                break;
            end
        end
        check({tag, "_batch_done_seen"}, seen, 1);
        repeat (6) step();
        check({tag, "_beat_count"}, beat_count, total);
        check({tag, "_single_done_pulse"}, done_cnt, exp_done);
        check({tag, "_all_beats_out"}, exp_q.size(), 0);
        check({tag, "_all_grants_seen"}, exp_gnt.size(), 0);
        check({tag, "_protocol_err"}, protocol_err, exp_err);
    endtask

    task automatic set_plain(input int bmin, input int bmax, input int gp, input int rp);
        for (int i = 0; i < NP; i++) begin
            nbeats[i] = $urandom_range(bmin, bmax);
            grp[i]    = 0;
        end
        gap_pct = gp; ready_pct = rp; ready_hold = 0;
        ign_start_cyc = -1; stall_chk_cyc = -1; inj_en = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; batch_start = 1'b0; pe_request = '0; pe_valid = '0;
        pe_finish = '0; pe_data = '0; out_ready = 1'b0; m_rr = 0;
        for (int i = 0; i < NP; i++) begin nbeats[i] = 0; grp[i] = -1; fin[i] = 1; sent[i] = 0; dly[i] = -1; end
        cyc = 0; gap_pct = 0; ready_pct = 100; ready_hold = 0; ign_start_cyc = -1;
        stall_chk_cyc = -1; inj_en = 0; inj_done = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_permit", pe_permit, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_batch_done", batch_done, 0);
        check("rst_beat_count", beat_count, 0);
        check("rst_protocol_err", protocol_err, 0);
        reset = 1'b0;

        // A: everyone requests, 3 beats each, host always ready
        set_plain(3, 3, 0, 100);
        run_batch("A", 0, 1, 0);

        // B: PE0 streams 20 beats with the host stalled for 100 cycles
        set_plain(1, 6, 0, 70);
        nbeats[0] = 20; ready_hold = 100; stall_chk_cyc = 80;
        run_batch("B", 1, 2, 0);

        // C: random gaps/backpressure, stray valid from PE1 while PE0 granted,
        //    and a batch_start mid-batch that must be ignored
        set_plain(1, 8, 30, 60);
        inj_en = 1; ign_start_cyc = 10;
        run_batch("C", 1, 3, 1);

        // D: staggered requests exercising pointer wrap
        set_plain(1, 4, 0, 100);
        grp[0] = 1; grp[1] = 0; grp[2] = 2; grp[3] = 1;
        run_batch("D", 1, 4, 1);

        // E: reset in the middle of a grant with 5 beats buffered
        set_plain(1, 1, 0, 0);
        grp[1] = -1; grp[2] = -1; grp[3] = -1; nbeats[0] = 10; ready_hold = 100000;
        begin_batch(1);
        begin
            bit got5 = 0;
            for (int t = 0; t < 200; t++) begin
                step();
                if (sent[0] == 5) begin got5 = 1; break; end
            end
            check("E_five_beats_sent", got5, 1);
        end
        @(posedge clk); #1;
        check("E_pre_reset_permit", pe_permit, 1);
        reset = 1'b1; pe_valid = '0; pe_request = '0; pe_finish = '0;
        for (int i = 0; i < NP; i++) fin[i] = 1;
        @(posedge clk); #1;
        exp_q.delete(); exp_gnt.delete(); m_rr = 0;
        check("E_reset_permit", pe_permit, 0);
        check("E_reset_out_valid", out_valid, 0);
        check("E_reset_beat_count", beat_count, 0);
        check("E_reset_protocol_err", protocol_err, 0);
        reset = 1'b0;

        // F: fresh batch after reset, no batch_start needed
        set_plain(1, 10, 20, 50);
        run_batch("F", 0, 5, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
